// File: rtl/ctrl_pipeline.sv
// Control-signal carrier for the EX/MEM/WB stages of the 5-stage MIPS_32 core,
// with load-use stall, branch flush and operand forwarding selects.
module ctrl_pipeline #(
  parameter int REG_W  = 5,
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              regWrite,
  input  logic              regDest,
  input  logic              aluSrc,
  input  logic              branch,
  input  logic              memWrite,
  input  logic              memtoReg,
  input  logic [ALUC_W-1:0] aluControl,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              ex_zero,
  output logic              ex_regWrite,
  output logic              ex_aluSrc,
  output logic              ex_branch,
  output logic              ex_memWrite,
  output logic              ex_memtoReg,
  output logic [ALUC_W-1:0] ex_aluControl,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_writeReg,
  output logic              mem_regWrite,
  output logic              mem_memWrite,
  output logic              mem_memtoReg,
  output logic [REG_W-1:0]  mem_writeReg,
  output logic              wb_regWrite,
  output logic              wb_memtoReg,
  output logic [REG_W-1:0]  wb_writeReg,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB
);

  logic              ex_valid_q, ex_valid_d;
  logic              ex_regWrite_q, ex_regWrite_d, ex_aluSrc_q, ex_aluSrc_d;
  logic              ex_branch_q, ex_branch_d, ex_memWrite_q, ex_memWrite_d;
  logic              ex_memtoReg_q, ex_memtoReg_d;
  logic [ALUC_W-1:0] ex_aluControl_q, ex_aluControl_d;
  logic [REG_W-1:0]  ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_writeReg_q, ex_writeReg_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_regWrite_q, mem_regWrite_d, mem_memWrite_q, mem_memWrite_d;
  logic              mem_memtoReg_q, mem_memtoReg_d;
  logic [REG_W-1:0]  mem_writeReg_q, mem_writeReg_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_regWrite_q, wb_regWrite_d, wb_memtoReg_q, wb_memtoReg_d;
  logic [REG_W-1:0]  wb_writeReg_q, wb_writeReg_d;
  logic              load_use, ex_bubble;

  // Bank outputs are gated by their valid bit so a bubble never leaks controls.
  assign ex_regWrite   = ex_valid_q & ex_regWrite_q;
  assign ex_aluSrc     = ex_valid_q & ex_aluSrc_q;
  assign ex_branch     = ex_valid_q & ex_branch_q;
  assign ex_memWrite   = ex_valid_q & ex_memWrite_q;
  assign ex_memtoReg   = ex_valid_q & ex_memtoReg_q;
  assign ex_aluControl = ex_valid_q ? ex_aluControl_q : '0;
  assign ex_rs         = ex_valid_q ? ex_rs_q : '0;
  assign ex_rt         = ex_valid_q ? ex_rt_q : '0;
  assign ex_writeReg   = ex_valid_q ? ex_writeReg_q : '0;
  assign mem_regWrite  = mem_valid_q & mem_regWrite_q;
  assign mem_memWrite  = mem_valid_q & mem_memWrite_q;
  assign mem_memtoReg  = mem_valid_q & mem_memtoReg_q;
  assign mem_writeReg  = mem_valid_q ? mem_writeReg_q : '0;
  assign wb_regWrite   = wb_valid_q & wb_regWrite_q;
  assign wb_memtoReg   = wb_valid_q & wb_memtoReg_q;
  assign wb_writeReg   = wb_valid_q ? wb_writeReg_q : '0;

  // Hazard detection: flush wins, since the ID instruction is discarded anyway.
  assign load_use = ex_memtoReg & ex_regWrite & (ex_writeReg != '0) & id_valid &
                    ((ex_writeReg == id_rs) | (ex_writeReg == id_rt));
  assign flush     = ex_branch & ex_zero;
  assign stall     = load_use & ~flush;
  assign ex_bubble = flush | load_use | ~id_valid;

  // MEM beats WB because it holds the younger result.
  assign fwdA = (mem_regWrite && mem_writeReg != '0 && mem_writeReg == ex_rs) ? 2'b10 :
                (wb_regWrite  && wb_writeReg  != '0 && wb_writeReg  == ex_rs) ? 2'b01 : 2'b00;
  assign fwdB = (mem_regWrite && mem_writeReg != '0 && mem_writeReg == ex_rt) ? 2'b10 :
                (wb_regWrite  && wb_writeReg  != '0 && wb_writeReg  == ex_rt) ? 2'b01 : 2'b00;

  always_comb begin
    ex_valid_d      = 1'b0;
    ex_regWrite_d   = 1'b0;
    ex_aluSrc_d     = 1'b0;
    ex_branch_d     = 1'b0;
    ex_memWrite_d   = 1'b0;
    ex_memtoReg_d   = 1'b0;
    ex_aluControl_d = '0;
    ex_rs_d         = '0;
    ex_rt_d         = '0;
    ex_writeReg_d   = '0;
    // ID -> EX
    if (!ex_bubble) begin
      ex_valid_d      = 1'b1;
      ex_regWrite_d   = regWrite;
      ex_aluSrc_d     = aluSrc;
      ex_branch_d     = branch;
      ex_memWrite_d   = memWrite;
      ex_memtoReg_d   = memtoReg;
      ex_aluControl_d = aluControl;
      ex_rs_d         = id_rs;
      ex_rt_d         = id_rt;
      ex_writeReg_d   = regDest ? id_rd : id_rt;
    end
    // EX -> MEM
    mem_valid_d    = ex_valid_q;
    mem_regWrite_d = ex_regWrite;
    mem_memWrite_d = ex_memWrite;
    mem_memtoReg_d = ex_memtoReg;
    mem_writeReg_d = ex_writeReg;
    // MEM -> WB
    wb_valid_d     = mem_valid_q;
    wb_regWrite_d  = mem_regWrite;
    wb_memtoReg_d  = mem_memtoReg;
    wb_writeReg_d  = mem_writeReg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_regWrite_q   <= 1'b0;
      ex_aluSrc_q     <= 1'b0;
      ex_branch_q     <= 1'b0;
      ex_memWrite_q   <= 1'b0;
      ex_memtoReg_q   <= 1'b0;
      ex_aluControl_q <= '0;
      ex_rs_q         <= '0;
      ex_rt_q         <= '0;
      ex_writeReg_q   <= '0;
      mem_valid_q     <= 1'b0;
      mem_regWrite_q  <= 1'b0;
      mem_memWrite_q  <= 1'b0;
      mem_memtoReg_q  <= 1'b0;
      mem_writeReg_q  <= '0;
      wb_valid_q      <= 1'b0;
      wb_regWrite_q   <= 1'b0;
      wb_memtoReg_q   <= 1'b0;
      wb_writeReg_q   <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_regWrite_q   <= ex_regWrite_d;
      ex_aluSrc_q     <= ex_aluSrc_d;
      ex_branch_q     <= ex_branch_d;
      ex_memWrite_q   <= ex_memWrite_d;
      ex_memtoReg_q   <= ex_memtoReg_d;
      ex_aluControl_q <= ex_aluControl_d;
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_writeReg_q   <= ex_writeReg_d;
      mem_valid_q     <= mem_valid_d;
      mem_regWrite_q  <= mem_regWrite_d;
      mem_memWrite_q  <= mem_memWrite_d;
      mem_memtoReg_q  <= mem_memtoReg_d;
      mem_writeReg_q  <= mem_writeReg_d;
      wb_valid_q      <= wb_valid_d;
      wb_regWrite_q   <= wb_regWrite_d;
      wb_memtoReg_q   <= wb_memtoReg_d;
      wb_writeReg_q   <= wb_writeReg_d;
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed hazard scenarios plus a randomized run
// checked against an instruction-level model of the EX/MEM/WB pipeline.
module tb_ctrl_pipeline;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       rd_sel;
    logic       as;
    logic       br;
    logic       mw;
    logic       m2r;
    logic [2:0] al;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst;
  logic ex_zero;
  ins_t id;

  logic       ex_regWrite, ex_aluSrc, ex_branch, ex_memWrite, ex_memtoReg;
  logic [2:0] ex_aluControl;
  logic [4:0] ex_rs, ex_rt, ex_writeReg;
  logic       mem_regWrite, mem_memWrite, mem_memtoReg;
  logic [4:0] mem_writeReg;
  logic       wb_regWrite, wb_memtoReg;
  logic [4:0] wb_writeReg;
  logic       stall, flush;
  logic [1:0] fwdA, fwdB;

  int n_vec = 0;
  int n_err = 0;

  ctrl_pipeline #(.REG_W(5), .ALUC_W(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id.v),
    .regWrite(id.rw), .regDest(id.rd_sel), .aluSrc(id.as), .branch(id.br),
    .memWrite(id.mw), .memtoReg(id.m2r), .aluControl(id.al),
    .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd), .ex_zero(ex_zero),
    .ex_regWrite(ex_regWrite), .ex_aluSrc(ex_aluSrc), .ex_branch(ex_branch),
    .ex_memWrite(ex_memWrite), .ex_memtoReg(ex_memtoReg), .ex_aluControl(ex_aluControl),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_writeReg(ex_writeReg),
    .mem_regWrite(mem_regWrite), .mem_memWrite(mem_memWrite), .mem_memtoReg(mem_memtoReg),
    .mem_writeReg(mem_writeReg), .wb_regWrite(wb_regWrite), .wb_memtoReg(wb_memtoReg),
    .wb_writeReg(wb_writeReg), .stall(stall), .flush(flush), .fwdA(fwdA), .fwdB(fwdB)
  );

  always #5 clk = ~clk;

  wire [22:0] ex_bus  = {ex_regWrite, ex_aluSrc, ex_branch, ex_memWrite, ex_memtoReg,
                         ex_aluControl, ex_rs, ex_rt, ex_writeReg};
  wire [43:0] dut_vec = {ex_bus, mem_regWrite, mem_memWrite, mem_memtoReg, mem_writeReg,
                         wb_regWrite, wb_memtoReg, wb_writeReg, stall, flush, fwdA, fwdB};

  // Reference model: whole instruction records sitting in each stage.
  ins_t m_ex = '0, m_mem = '0, m_wb = '0;

  function automatic logic [4:0] dest(input ins_t e);
    if (!e.v) return 5'd0;
    return e.rd_sel ? e.rd : e.rt;
  endfunction

  function automatic logic writes(input ins_t e);
    return e.v && e.rw && dest(e) != 5'd0;
  endfunction

  function automatic logic m_load_use();
    return m_ex.v && m_ex.m2r && m_ex.rw && dest(m_ex) != 5'd0 && id.v &&
           (dest(m_ex) == id.rs || dest(m_ex) == id.rt);
  endfunction

  function automatic logic m_flush();
    return m_ex.v && m_ex.br && ex_zero;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (writes(m_mem) && dest(m_mem) == src) return 2'b10;
    if (writes(m_wb) && dest(m_wb) == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [43:0] model_vec();
    logic [22:0] exb;
    exb = m_ex.v ? {m_ex.rw, m_ex.as, m_ex.br, m_ex.mw, m_ex.m2r, m_ex.al,
                    m_ex.rs, m_ex.rt, dest(m_ex)} : 23'd0;
    return {exb,
            m_mem.v & m_mem.rw, m_mem.v & m_mem.mw, m_mem.v & m_mem.m2r, dest(m_mem),
            m_wb.v & m_wb.rw, m_wb.v & m_wb.m2r, dest(m_wb),
            m_load_use() & ~m_flush(), m_flush(),
            m_fwd(m_ex.v ? m_ex.rs : 5'd0), m_fwd(m_ex.v ? m_ex.rt : 5'd0)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (m_flush() || m_load_use() || !id.v) ? ins_t'('0) : id;
    end
  end

  function automatic ins_t mk(input logic rw, rd_sel, as, br, mw, m2r,
                              input logic [2:0] al, input logic [4:0] rs, rt, rd);
    ins_t i;
    i = '0;
    i.v = 1'b1; i.rw = rw; i.rd_sel = rd_sel; i.as = as; i.br = br;
    i.mw = mw; i.m2r = m2r; i.al = al; i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    i = ins_t'($urandom);
    i.v  = ($urandom_range(0, 7) != 0);
    i.rs = 5'($urandom_range(0, 7));
    i.rt = 5'($urandom_range(0, 7));
    i.rd = 5'($urandom_range(0, 7));
    return i;
  endfunction

  // Apply one cycle of inputs mid-low-phase; outputs are then settled for checking.
  task automatic drive(input ins_t i, input logic z, input logic r);
    @(negedge clk);
    id = i; ex_zero = z; rst = r;
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 4; k++) drive('0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) drive(mk(1, 1, 0, 0, 0, 0, 3'd2, 5'd1, 5'd2, 5'(k + 3)), 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) drive(rnd_ins(), 1'($urandom), 1'b1);
    drive(rnd_ins(), 1'($urandom), 1'b0);
    n_vec++;
    if (dut_vec !== 44'd0) begin
      n_err++; $display("FAIL reset_state: got %h expected %h", dut_vec, 44'd0);
    end
  endtask

  task automatic test_rtype();
    drain();
    drive(mk(1, 1, 0, 0, 0, 0, 3'b010, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
    n_vec++;
    if ({ex_regWrite, ex_aluControl, ex_rs, ex_rt, ex_writeReg} !== {1'b1, 3'b010, 5'd1, 5'd2, 5'd3}) begin
      n_err++; $display("FAIL rtype_ex: got %b/%h/%0d/%0d/%0d expected 1/2/1/2/3",
                        ex_regWrite, ex_aluControl, ex_rs, ex_rt, ex_writeReg);
    end
    drive('0, 1'b0, 1'b0);
    n_vec++;
    if ({mem_regWrite, mem_writeReg} !== {1'b1, 5'd3}) begin
      n_err++; $display("FAIL rtype_mem: got %b/%0d expected 1/3", mem_regWrite, mem_writeReg);
    end
    drive('0, 1'b0, 1'b0);
    n_vec++;
    if ({wb_regWrite, wb_writeReg} !== {1'b1, 5'd3}) begin
      n_err++; $display("FAIL rtype_wb: got %b/%0d expected 1/3", wb_regWrite, wb_writeReg);
    end
  endtask

  task automatic test_forwarding();
    drain();
    drive(mk(1, 1, 0, 0, 0, 0, 3'b010, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0);
    drive(mk(1, 1, 0, 0, 0, 0, 3'b110, 5'd3, 5'd3, 5'd4), 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
    n_vec++;
    if ({fwdA, fwdB} !== 4'b1010) begin
      n_err++; $display("FAIL fwd_mem: got %b/%b expected 10/10", fwdA, fwdB);
    end
    drain();
    drive(mk(1, 1, 0, 0, 0, 0, 3'b010, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0);
    drive(mk(1, 1, 0, 0, 0, 0, 3'b010, 5'd7, 5'd8, 5'd9), 1'b0, 1'b0);
    drive(mk(1, 1, 0, 0, 0, 0, 3'b110, 5'd3, 5'd3, 5'd4), 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
    n_vec++;
    if ({fwdA, fwdB} !== 4'b0101) begin
      n_err++; $display("FAIL fwd_wb: got %b/%b expected 01/01", fwdA, fwdB);
    end
  endtask

  task automatic test_load_use();
    ins_t dep;
    dep = mk(1, 1, 0, 0, 0, 0, 3'b010, 5'd5, 5'd6, 5'd7);
    drain();
    drive(mk(1, 0, 1, 0, 0, 1, 3'b010, 5'd1, 5'd5, 5'd0), 1'b0, 1'b0);
    drive(dep, 1'b0, 1'b0);
    n_vec++;
    if ({stall, flush} !== 2'b10) begin
      n_err++; $display("FAIL loaduse_stall: got stall=%b flush=%b expected 1/0", stall, flush);
    end
    drive(dep, 1'b0, 1'b0);
    n_vec++;
    if ({stall, ex_bus} !== 24'd0) begin
      n_err++; $display("FAIL loaduse_bubble: got stall=%b ex=%h expected 0/0", stall, ex_bus);
    end
    drive('0, 1'b0, 1'b0);
    // The stall cycle lets the load reach WB by the time its consumer is in EX.
    n_vec++;
    if ({ex_rs, fwdA, fwdB} !== {5'd5, 2'b01, 2'b00}) begin
      n_err++; $display("FAIL loaduse_fwd: got rs=%0d fwdA=%b fwdB=%b expected 5/01/00", ex_rs, fwdA, fwdB);
    end
  endtask

  task automatic test_zero_guard();
    drain();
    drive(mk(1, 0, 1, 0, 0, 1, 3'b010, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0);
    drive(mk(1, 1, 0, 0, 0, 0, 3'b010, 5'd0, 5'd0, 5'd6), 1'b0, 1'b0);
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL zero_stall: got %b expected 0", stall);
    end
    drive('0, 1'b0, 1'b0);
    n_vec++;
    if ({fwdA, fwdB} !== 4'b0000) begin
      n_err++; $display("FAIL zero_fwd: got %b/%b expected 00/00", fwdA, fwdB);
    end
  endtask

  task automatic test_branch();
    ins_t ldbr, dep;
    ldbr = mk(1, 0, 0, 1, 0, 1, 3'b110, 5'd1, 5'd5, 5'd0);
    dep  = mk(1, 1, 0, 0, 0, 0, 3'b010, 5'd5, 5'd6, 5'd7);
    drain();
    drive(ldbr, 1'b0, 1'b0);
    drive(dep, 1'b1, 1'b0);
    n_vec++;
    if ({flush, stall} !== 2'b10) begin
      n_err++; $display("FAIL branch_taken: got flush=%b stall=%b expected 1/0", flush, stall);
    end
    drive('0, 1'b0, 1'b0);
    n_vec++;
    if ({flush, ex_bus} !== 24'd0) begin
      n_err++; $display("FAIL branch_bubble: got flush=%b ex=%h expected 0/0", flush, ex_bus);
    end
    drain();
    drive(ldbr, 1'b0, 1'b0);
    drive(dep, 1'b0, 1'b0);
    n_vec++;
    if ({flush, stall} !== 2'b01) begin
      n_err++; $display("FAIL branch_untaken_stall: got flush=%b stall=%b expected 0/1", flush, stall);
    end
    drain();
    drive(mk(0, 0, 0, 1, 0, 0, 3'b110, 5'd1, 5'd2, 5'd0), 1'b0, 1'b0);
    drive(dep, 1'b0, 1'b0);
    n_vec++;
    if ({flush, stall} !== 2'b00) begin
      n_err++; $display("FAIL branch_untaken: got flush=%b stall=%b expected 0/0", flush, stall);
    end
    drive('0, 1'b0, 1'b0);
    n_vec++;
    if ({ex_regWrite, ex_writeReg} !== {1'b1, 5'd7}) begin
      n_err++; $display("FAIL branch_advance: got %b/%0d expected 1/7", ex_regWrite, ex_writeReg);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      drive(rnd_ins(), 1'($urandom), ($urandom_range(0, 39) == 0));
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++; $display("FAIL random[%0d]: got %h expected %h", k, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    id = '0; rst = 1'b1; ex_zero = 1'b0;
    test_reset();
    test_rtype();
    test_forwarding();
    test_load_use();
    test_zero_guard();
    test_branch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
